// File: rtl/alu_seq_muldiv.sv
// Registered WIDTH-bit ALU for the EX stage: single-cycle logic/arithmetic ops plus
// iterative unsigned multiply (shift-add) and restoring divide, one bit per clock.
module alu_seq_muldiv #(
    parameter int WIDTH = 16,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcod,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             Cout,
    output logic             V,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             dz,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_SLT  = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_MULU = 3'd6;
    localparam logic [2:0] OP_DIVU = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_ph;
    logic [WIDTH-1:0] r_pl;

    logic             w_lt, w_eq, w_gt, w_last;
    logic [WIDTH:0]   w_add, w_sub, w_mul_sum, w_div_sh, w_div_diff;
    logic [WIDTH-1:0] w_res, w_ph_nxt, w_pl_nxt;
    logic             w_cout, w_v;

    assign w_lt  = $signed(X) <  $signed(Y);
    assign w_eq  = X == Y;
    assign w_gt  = $signed(X) >  $signed(Y);
    assign w_add = {1'b0, X} + {1'b0, Y}  + {{WIDTH{1'b0}}, Cin};
    assign w_sub = {1'b0, X} + {1'b0, ~Y} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_v    = 1'b0;
        case (opcod)
            OP_AND: w_res = X & Y;
            OP_OR:  w_res = X | Y;
            OP_ADD: begin
                w_res  = w_add[WIDTH-1:0];
                w_cout = w_add[WIDTH];
                w_v    = (X[WIDTH-1] == Y[WIDTH-1]) && (w_add[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SUB: begin
                w_res  = w_sub[WIDTH-1:0];
                w_cout = w_sub[WIDTH];
                w_v    = (X[WIDTH-1] != Y[WIDTH-1]) && (w_sub[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_lt};
            OP_NOR: w_res = ~(X | Y);
            default: ;
        endcase
    end

    // r_ph/r_pl hold {product high, multiplier} for MUL and {remainder, dividend} for DIV;
    // r_opnd is the multiplicand or divisor.
    assign w_mul_sum  = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_div_sh   = {r_ph, r_pl[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_opnd};
    assign w_last     = r_cnt == CW'(WIDTH-1);

    always_comb begin
        w_ph_nxt = w_mul_sum[WIDTH:1];
        w_pl_nxt = {w_mul_sum[0], r_pl[WIDTH-1:1]};
        if (r_state == S_DIV) begin
            if (!w_div_diff[WIDTH]) begin
                w_ph_nxt = w_div_diff[WIDTH-1:0];
                w_pl_nxt = {r_pl[WIDTH-2:0], 1'b1};
            end else begin
                w_ph_nxt = w_div_sh[WIDTH-1:0];
                w_pl_nxt = {r_pl[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && opcod == OP_MULU)
                    w_state_nxt = S_MUL;
                else if (start && opcod == OP_DIVU && Y != '0)
                    w_state_nxt = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (w_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_opnd <= '0;
            r_ph   <= '0;
            r_pl   <= '0;
            out    <= '0;
            hi     <= '0;
            Cout   <= 1'b0;
            V      <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            dz     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lt     <= w_lt;
                        eq     <= w_eq;
                        gt     <= w_gt;
                        dz     <= 1'b0;
                        r_cnt  <= '0;
                        r_ph   <= '0;
                        r_pl   <= (opcod == OP_MULU) ? Y : X;
                        r_opnd <= (opcod == OP_MULU) ? X : Y;
                        if (opcod == OP_MULU || (opcod == OP_DIVU && Y != '0)) begin
                            busy <= 1'b1;
                        end else if (opcod == OP_DIVU) begin
                            out  <= '1;
                            hi   <= X;
                            Cout <= 1'b0;
                            V    <= 1'b0;
                            dz   <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            out  <= w_res;
                            hi   <= '0;
                            Cout <= w_cout;
                            V    <= w_v;
                            done <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_ph  <= w_ph_nxt;
                    r_pl  <= w_pl_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    done  <= w_last;
                    if (w_last) begin
                        out  <= w_pl_nxt;
                        hi   <= w_ph_nxt;
                        Cout <= 1'b0;
                        V    <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, registered ALU for the pipelined datapath EX stage.
- Generalises the 16-bit combinational ALU to WIDTH bits: registered outputs, start/done handshake.
- Adds two iterative operations: unsigned multiply (shift-add) and unsigned divide (restoring), one bit per clock.
- Logic/arithmetic ops complete in one cycle. MULU/DIVU stall the pipeline via busy.

Parameters:
- WIDTH, 16, operand/result width; legal values 8..32.
- CW, 6, iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- opcod  in  3  operation select: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 MULU, 7 DIVU.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- Cin  in  1  carry in; used by ADD only.
- out  out  WIDTH  result (MULU low half, DIVU quotient).
- hi  out  WIDTH  MULU high half, DIVU remainder; 0 for other ops.
- Cout  out  1  carry out (ADD/SUB); 0 otherwise.
- V  out  1  signed overflow (ADD/SUB); 0 otherwise.
- lt, eq, gt  out  1 each  signed compare of X vs Y, captured at start.
- dz  out  1  divide-by-zero flag (DIVU with Y=0).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result valid.

Behaviour:
- Reset (async, immediate):
  - out=0, hi=0, Cout=0, V=0, lt=0, eq=0, gt=0, dz=0, busy=0, done=0.
  - state=IDLE, counter=0.
- States: IDLE, MUL, DIV.
- IDLE, start=1 sampled at edge E:
  - X, Y, opcod latched at E; lt/eq/gt registered at E for every op.
  - Ops 0-5: result, Cout, V registered at E; done=1 for the following cycle; busy stays 0; state stays IDLE.
  - ADD: {Cout,out} = X + Y + Cin.
  - SUB: X + ~Y + 1, Cin ignored; Cout=1 means no borrow.
  - V = signed overflow for ADD/SUB.
  - SLT: out = {0...,lt}.
  - NOR: out = ~(X|Y).
  - Ops 0-5 leave hi=0.
  - MULU: state=MUL, busy=1 from E; accumulator cleared; counter=0.
  - DIVU, Y!=0: state=DIV, busy=1 from E.
  - DIVU, Y=0: completes at E as a single-cycle op: out = all ones, hi = X, dz=1, done=1; stays IDLE.
  - dz clears on the next start.
- MUL: one shift-add step per edge. At the WIDTH-th edge after E:
  - {hi,out} = full 2*WIDTH product.
  - done=1 next cycle, busy=0, state=IDLE.
- DIV: one restoring step per edge. At the WIDTH-th edge after E:
  - out = quotient, hi = remainder.
  - done=1 next cycle, busy=0, state=IDLE.
- Latency:
  - Ops 0-5: done high in cycle E+1.
  - MULU/DIVU: done high in cycle E+WIDTH+1; busy high cycles E+1..E+WIDTH.
- done is exactly one cycle wide and deasserts automatically.
- Outputs hold their last result until the next completion; no change on non-started cycles.
- start with busy=1: ignored, with no side effects. X/Y/opcod may change freely during MUL/DIV; the latched copies are used.
- start in the completion cycle:
  - Sampled when busy is already 0, i.e. the cycle done is high.
  - Back-to-back ops allowed; a single-cycle op gives done on consecutive cycles.
- rst mid-operation: aborts immediately to reset values; no done is issued.
- Arithmetic is unsigned for MULU/DIVU; compares and V are signed two's complement.

Test Plan (WIDTH=16):
- ADD X=0x7FFF, Y=0x0001, Cin=0 -> out=0x8000, V=1, Cout=0, gt=1, done the next cycle, busy never high.
- SUB X=0x0005, Y=0x0007 -> out=0xFFFE, Cout=0, V=0, lt=1. Then SLT with the same operands -> out=0x0001.
- MULU X=300, Y=500 -> busy for 16 cycles; done at E+17; out=0x49F0, hi=0x0002. Also 0xFFFF*0xFFFF -> hi=0xFFFE, out=0x0001.
- DIVU X=100, Y=7 -> out=14, hi=2, dz=0 at E+17. DIVU X=0x1234, Y=0 -> out=0xFFFF, hi=0x1234, dz=1, done at E+1.
- MULU started, start pulsed with ADD at E+5 -> ADD ignored; MULU result unchanged. An ADD issued in the MULU done cycle completes one cycle later.
- rst asserted at E+8 of DIVU -> all outputs 0 immediately; no done pulse. Next MULU 3*4 after reset release -> out=12.
